// File: rtl/tv80_dbg_pkg.sv
// Shared definitions for the TV80 register-file debug dump.
// TV80_REG_DUMP_CSUM_EN adds the trailing checksum state.
package tv80_dbg_pkg;

    localparam int unsigned REG_PAIRS  = 8;
    localparam int unsigned DUMP_BYTES = 16;

    localparam logic [2:0] PAIR_BC  = 3'd0;
    localparam logic [2:0] PAIR_DE  = 3'd1;
    localparam logic [2:0] PAIR_HL  = 3'd2;
    localparam logic [2:0] PAIR_IX  = 3'd3;
    localparam logic [2:0] PAIR_BCA = 3'd4;
    localparam logic [2:0] PAIR_DEA = 3'd5;
    localparam logic [2:0] PAIR_HLA = 3'd6;
    localparam logic [2:0] PAIR_IY  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND_H,
        ST_SEND_L,
`ifdef TV80_REG_DUMP_CSUM_EN
        ST_CSUM,
`endif
        ST_DONE
    } dump_state_t;

endpackage

// File: rtl/tv80_reg_dump.sv
// Walks the eight register pairs on the spare read port and streams 16 bytes.
// Define TV80_REG_DUMP_CSUM_EN to append a mod-256 checksum byte.
module tv80_reg_dump
    import tv80_dbg_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       busy,
    output logic       hold_req,
    output logic [2:0] rd_addr,
    input  logic [7:0] rd_h,
    input  logic [7:0] rd_l,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       done
);

    dump_state_t state_q;
    logic [2:0]  idx_q;
    logic [2:0]  rd_addr_q;
    logic [7:0]  hold_l_q;
    logic [7:0]  out_data_q;
    logic        out_valid_q;
    logic        busy_q;
    logic        done_q;
    logic        accept;
`ifdef TV80_REG_DUMP_CSUM_EN
    logic [7:0]  csum_q;
`endif

    assign accept = out_valid_q && out_ready;

    // The high byte goes straight into out_data_q, which doubles as hold_h.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= PAIR_BC;
            rd_addr_q   <= PAIR_BC;
            hold_l_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef TV80_REG_DUMP_CSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_LOAD;
                        idx_q     <= PAIR_BC;
                        rd_addr_q <= PAIR_BC;
                        busy_q    <= 1'b1;
`ifdef TV80_REG_DUMP_CSUM_EN
                        csum_q    <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    out_data_q  <= rd_h;
                    hold_l_q    <= rd_l;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_SEND_H;
                end
                ST_SEND_H: begin
                    if (accept) begin
                        out_data_q <= hold_l_q;
                        state_q    <= ST_SEND_L;
`ifdef TV80_REG_DUMP_CSUM_EN
                        csum_q     <= csum_q + out_data_q;
`endif
                    end
                end
                ST_SEND_L: begin
                    if (accept) begin
`ifdef TV80_REG_DUMP_CSUM_EN
                        csum_q <= csum_q + out_data_q;
`endif
                        if (idx_q == PAIR_IY) begin
`ifdef TV80_REG_DUMP_CSUM_EN
                            out_data_q  <= csum_q + out_data_q;
                            state_q     <= ST_CSUM;
`else
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= ST_DONE;
`endif
                        end else begin
                            idx_q       <= idx_q + 3'd1;
                            rd_addr_q   <= idx_q + 3'd1;
                            out_valid_q <= 1'b0;
                            state_q     <= ST_LOAD;
                        end
                    end
                end
`ifdef TV80_REG_DUMP_CSUM_EN
                ST_CSUM: begin
                    if (accept) begin
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign hold_req  = busy_q;
    assign rd_addr   = rd_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule
